mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 256-bit line data memory between two cache miss handlers:
//  port 0 = D-cache, port 1 = I-cache. One transaction is in flight at a time.
//  Round-robin grant between the ports. A programmable latency counter models
//  DRAM access time in front of the zero-wait memory.
// PARAMETERS
//  LATENCY  4  cycles the memory enable is held per access, >=1
// PORTS
//  clk_i          in   1    clock; all state updates on posedge
//  rst_i          in   1    reset, asynchronous, active-high
//  req0_i/req1_i  in   1    request; held high until the matching ack
//  wr0_i/wr1_i    in   1    1 = write line, 0 = read line
//  addr0_i/addr1_i in  32   byte address; addr%4==0
//  wdata0_i/wdata1_i in 256 write line
//  rdata0_o/rdata1_o out 256 read line; both driven from one register
//  ack0_o/ack1_o  out  1    one-cycle completion pulse
//  mem_enable_o   out  1    memory enable
//  mem_write_o    out  1    memory write strobe
//  mem_addr_o     out  32   memory address
//  mem_data_o     out  256  memory write data
//  mem_data_i     in   256  memory read data; combinational while enabled
//  mem_ack_i      in   1    memory ready; sampled only on the final BUSY cycle
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, cnt=0; all outputs 0; rdata register = 0.
//  States:
//  - IDLE: if any req, pick the winner.
//    - Both requesting: winner = ptr. One requesting: that port.
//    - At the edge: latch addr/wdata/wr of the winner and its index (gnt).
//    - cnt <= LATENCY-1; go to BUSY.
//  - BUSY: mem_enable_o=1, mem_addr_o=addr_q, mem_data_o=wdata_q.
//    - mem_write_o = wr_q && cnt==0. Exactly one write strobe per write.
//    - cnt!=0: cnt decrements.
//    - cnt==0 && mem_ack_i: rdata_q <= mem_data_i (writes also capture;
//      the value is ignored). ptr <= ~gnt. Go to DONE.
//    - cnt==0 && !mem_ack_i: stay; cnt holds 0; strobe stays asserted.
//  - DONE: ack[gnt]=1 for exactly this cycle; go to IDLE.
//    The requester drops req by the next edge.
//  Latency: req seen in IDLE cycle t gives ack in cycle t+LATENCY+1, with
//  mem_ack_i=1. Minimum spacing between grants is LATENCY+2 cycles.
//  Boundaries:
//  - Requests arriving in BUSY or DONE wait; they are never dropped.
//  - A req deasserted before its grant is legal and ignored.
//  - Reset in BUSY with cnt>0: no write strobe is issued, so memory is
//    unchanged. All outputs are 0 asynchronously.
//  - Inputs of the non-granted port are never forwarded to memory.
//  - LATENCY=1: BUSY lasts one cycle, so the strobe comes in the first
//    BUSY cycle.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, BUSY, DONE}; PORT_D=0, PORT_I=1;
//  LINE_W=256; ADDR_W=32.
//  Sub-module rr_arb2 (combinational): inputs req[1:0] and ptr; outputs
//  valid and gnt.
//  The counter width is $clog2(LATENCY+1).
// TESTING (LATENCY=4, memory preloaded)
//  1 Read: req0 with addr 0x40 at cycle 0 -> mem_enable_o high cycles 1-4;
//    ack0_o only at cycle 5; rdata0_o = memory[0x10].
//  2 Write then read: req1 write 0xA5..A5 to 0x80 -> mem_write_o high only in
//    cycle 4; ack1 at cycle 5. A following read of 0x80 returns 0xA5..A5.
//  3 Both requests at cycle 0 after reset -> port 0 acked at cycle 5, port 1
//    acked at cycle 11. Repeating both requests: port 0 acked before port 1
//    again, since ptr alternates.
//  4 mem_ack_i held 0 for 3 extra cycles -> BUSY is extended by 3 cycles;
//    the ack is delayed by 3; exactly one write strobe window; no lost data.
//  5 rst_i pulsed in cycle 2 of a write -> outputs 0 immediately; no
//    mem_write_o; target line unchanged; next request behaves as in test 1.
//  6 Random req/wr/addr for 10k cycles against a reference model -> every
//    request acked exactly once; data matches; at most one access at a time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PORT_D = 0;   // D-cache miss handler
    localparam int PORT_I = 1;   // I-cache miss handler
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, and when both
// ports ask at once the pointer decides.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       gnt
);

    // Winner selection; gnt is don't-care when valid is low and is left at 0
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req == 2'b11) begin
            gnt = ptr;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the D-cache and I-cache miss handlers for the single
// line-wide data memory. One transaction at a time; a down-counter holds the
// memory enable for LATENCY cycles to model DRAM access time, and the final
// BUSY cycle waits for mem_ack_i before completing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wr0_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [LINE_W-1:0] wdata0_i,
    input  logic [LINE_W-1:0] wdata1_i,
    output logic [LINE_W-1:0] rdata0_o,
    output logic [LINE_W-1:0] rdata1_o,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state;
    logic              ptr;
    logic              gnt_q;
    logic [CNT_W-1:0]  cnt;
    logic              en_q;
    logic              write_q;
    logic [1:0]        ack_q;
    logic [LINE_W-1:0] rdata_q;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              arb_valid;
    logic              arb_gnt;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [LINE_W-1:0] win_wdata;

    rr_arb2 u_arb (
        .req   ({req1_i, req0_i}),
        .ptr   (ptr),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    // Steer the winning port's transaction fields; the loser never reaches memory
    always_comb begin
        win_wr    = wr0_i;
        win_addr  = addr0_i;
        win_wdata = wdata0_i;
        if (arb_gnt) begin
            win_wr    = wr1_i;
            win_addr  = addr1_i;
            win_wdata = wdata1_i;
        end
    end

    // Transaction payload captured at grant; it only reaches the outputs while enabled
    always_ff @(posedge clk_i) begin
        if (state == IDLE && arb_valid) begin
            wr_q    <= win_wr;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
        end
    end

    // Control FSM: grant in IDLE, count down the access in BUSY, pulse ack in DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            gnt_q   <= 1'b0;
            cnt     <= '0;
            en_q    <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q   <= arb_gnt;
                        cnt     <= CNT_W'(LATENCY - 1);
                        en_q    <= 1'b1;
                        // With a single-cycle access the first BUSY cycle is also the last
                        write_q <= win_wr && (LATENCY == 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt     <= cnt - CNT_W'(1);
                        write_q <= wr_q && (cnt == CNT_W'(1));
                    end else if (mem_ack_i) begin
                        // Writes capture too; the requester ignores rdata on a write
                        rdata_q      <= mem_data_i;
                        ptr          <= ~gnt_q;
                        en_q         <= 1'b0;
                        write_q      <= 1'b0;
                        ack_q[gnt_q] <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    ack_q <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_enable_o = en_q;
    assign mem_write_o  = write_q;
    assign mem_addr_o   = en_q ? addr_q : '0;
    assign mem_data_o   = en_q ? wdata_q : '0;
    assign ack0_o       = ack_q[PORT_D];
    assign ack1_o       = ack_q[PORT_I];
    assign rdata0_o     = rdata_q;
    assign rdata1_o     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req   [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] wdata [2];
    logic [255:0] rdata0, rdata1;
    logic         ack0, ack1;
    logic         mem_en, mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_do, mem_di;
    logic         mem_ack = 1'b1;
    logic         preload = 1'b1;

    logic [255:0] mem [256];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // stats gathered by the per-cycle monitor
    logic         ack_seen [2];
    int           ack_cyc  [2];
    int           ack_cnt  [2];
    logic [255:0] ack_rdata[2];
    int           en_cycles = 0, wr_cycles = 0, wr_rises = 0, wr_first = -1;
    logic         wr_prev = 1'b0;

    // reference model
    logic         m_acc = 1'b0, m_done = 1'b0, m_gnt = 1'b0, m_wr = 1'b0, m_ptr = 1'b0;
    int           m_el = 0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wdata = '0, m_rdata = '0;
    logic [255:0] ref_mem [256];

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_i       (req[0]),
        .req1_i       (req[1]),
        .wr0_i        (wr[0]),
        .wr1_i        (wr[1]),
        .addr0_i      (addr[0]),
        .addr1_i      (addr[1]),
        .wdata0_i     (wdata[0]),
        .wdata1_i     (wdata[1]),
        .rdata0_o     (rdata0),
        .rdata1_o     (rdata1),
        .ack0_o       (ack0),
        .ack1_o       (ack1),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_do),
        .mem_data_i   (mem_di),
        .mem_ack_i    (mem_ack)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] pat(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // zero-wait line memory, word index = byte address / 4
    assign mem_di = mem[mem_addr[9:2]];

    always @(posedge clk_i) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_en && mem_wr && mem_ack) begin
            mem[mem_addr[9:2]] <= mem_do;
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model one cycle
    task automatic monitor();
        logic       e_wr;
        logic [7:0] idx;
        if (preload) for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        ack_seen[0] = ack0;
        ack_seen[1] = ack1;
        if (ack0) begin ack_cyc[0] = cyc; ack_cnt[0]++; ack_rdata[0] = rdata0; end
        if (ack1) begin ack_cyc[1] = cyc; ack_cnt[1]++; ack_rdata[1] = rdata1; end
        if (mem_en) en_cycles++;
        if (mem_en && mem_wr) begin
            wr_cycles++;
            if (!wr_prev) begin wr_rises++; wr_first = cyc; end
        end
        wr_prev = mem_en && mem_wr;

        if (rst_i) begin
            chk("reset_ctrl", 256'({mem_en, mem_wr, ack0, ack1}), 256'(0));
            chk("reset_addr", 256'(mem_addr), 256'(0));
            chk("reset_wdata", mem_do, 256'(0));
            chk("reset_rdata", rdata0 | rdata1, 256'(0));
            m_acc = 1'b0; m_done = 1'b0; m_ptr = 1'b0; m_rdata = '0;
        end else begin
            e_wr = m_acc && m_wr && (m_el >= LAT);
            chk("mem_enable", 256'(mem_en), 256'(m_acc));
            chk("mem_write", 256'(mem_wr), 256'(e_wr));
            chk("ack0", 256'(ack0), 256'(m_done && !m_gnt));
            chk("ack1", 256'(ack1), 256'(m_done && m_gnt));
            if (m_acc) begin
                chk("mem_addr", 256'(mem_addr), 256'(m_addr));
                chk("mem_data", mem_do, m_wdata);
            end
            chk("rdata0", rdata0, m_rdata);
            chk("rdata1", rdata1, m_rdata);

            idx = m_addr[9:2];
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_acc) begin
                if (m_el >= LAT && mem_ack) begin
                    m_rdata = ref_mem[idx];
                    if (m_wr) ref_mem[idx] = m_wdata;
                    m_acc  = 1'b0;
                    m_done = 1'b1;
                    m_ptr  = !m_gnt;
                end else begin
                    m_el++;
                end
            end else if (req[0] || req[1]) begin
                m_gnt   = (req[0] && req[1]) ? m_ptr : req[1];
                m_wr    = wr[m_gnt];
                m_addr  = addr[m_gnt];
                m_wdata = wdata[m_gnt];
                m_acc   = 1'b1;
                m_el    = 1;
            end
        end
    endtask

    // One clock: check at the falling edge, then return just after the rising edge
    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) if (ack_seen[p]) req[p] = 1'b0;
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [255:0] d);
        req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
    endtask

    task automatic wait_acks(input logic need0, input logic need1, input int bound);
        logic got0 = !need0, got1 = !need1;
        int   n = 0;
        while (!(got0 && got1) && n < bound) begin
            step();
            if (ack_seen[0]) got0 = 1'b1;
            if (ack_seen[1]) got1 = 1'b1;
            n++;
        end
        if (!(got0 && got1)) chk("ack_timeout", 256'({got1, got0}), 256'({need1, need0}));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0;
        step(); step();
        rst_i = 1'b0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int c0, c1, e0, w0, r0, a1;
        int issued[2], acked0[2], age[2];
        logic [255:0] d4;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            ack_seen[p] = 1'b0; ack_cyc[p] = -1; ack_cnt[p] = 0; ack_rdata[p] = '0;
        end
        step(); step();
        preload = 1'b0;
        rst_i = 1'b0;

        // 1: read of 0x40, plus a stray I-cache request withdrawn before any grant
        c0 = cyc; e0 = en_cycles; a1 = ack_cnt[1];
        issue(0, 1'b0, 32'h40, '0);
        step(); step();
        issue(1, 1'b0, 32'h44, '0);
        step();
        req[1] = 1'b0;
        wait_acks(1'b1, 1'b0, 40);
        chk("t1_ack_cycle", 256'(ack_cyc[0]), 256'(c0 + 5));
        chk("t1_enable_cycles", 256'(en_cycles - e0), 256'(4));
        chk("t1_rdata", ack_rdata[0], pat(16));
        chk("t1_withdrawn_req", 256'(ack_cnt[1]), 256'(a1));

        // 2: write 0xA5.. to 0x80 on the I-cache port, then read it back
        c0 = cyc; w0 = wr_cycles;
        issue(1, 1'b1, 32'h80, {32{8'hA5}});
        wait_acks(1'b0, 1'b1, 40);
        chk("t2_strobe_cycle", 256'(wr_first), 256'(c0 + 4));
        chk("t2_strobe_count", 256'(wr_cycles - w0), 256'(1));
        chk("t2_ack_cycle", 256'(ack_cyc[1]), 256'(c0 + 5));
        issue(0, 1'b0, 32'h80, '0);
        wait_acks(1'b1, 1'b0, 40);
        chk("t2_readback", ack_rdata[0], {32{8'hA5}});

        // 3: simultaneous requests right after reset, twice
        do_reset();
        c0 = cyc;
        issue(0, 1'b0, 32'hC0, '0);
        issue(1, 1'b0, 32'hE0, '0);
        wait_acks(1'b1, 1'b1, 60);
        chk("t3_port0_ack", 256'(ack_cyc[0]), 256'(c0 + 5));
        chk("t3_port1_ack", 256'(ack_cyc[1]), 256'(c0 + 11));
        c1 = cyc;
        issue(0, 1'b0, 32'hC0, '0);
        issue(1, 1'b0, 32'hE0, '0);
        wait_acks(1'b1, 1'b1, 60);
        chk("t3_repeat_port0_ack", 256'(ack_cyc[0]), 256'(c1 + 5));
        chk("t3_repeat_port1_ack", 256'(ack_cyc[1]), 256'(c1 + 11));
        chk("t3_repeat_rdata1", ack_rdata[1], pat(56));

        // 4: memory not ready for 3 extra cycles on a write
        c0 = cyc; w0 = wr_cycles; r0 = wr_rises;
        d4 = rand_line();
        mem_ack = 1'b0;
        issue(0, 1'b1, 32'h100, d4);
        for (int n = 0; n < 40 && !ack_seen[0]; n++) begin
            step();
            if (cyc == c0 + 7) mem_ack = 1'b1;
        end
        mem_ack = 1'b1;
        chk("t4_ack_cycle", 256'(ack_cyc[0]), 256'(c0 + 8));
        chk("t4_strobe_windows", 256'(wr_rises - r0), 256'(1));
        chk("t4_strobe_cycles", 256'(wr_cycles - w0), 256'(4));
        issue(1, 1'b0, 32'h100, '0);
        wait_acks(1'b0, 1'b1, 40);
        chk("t4_readback", ack_rdata[1], d4);

        // 5: reset during the countdown of a write
        w0 = wr_cycles;
        issue(1, 1'b1, 32'h200, rand_line());
        step(); step();
        #2;
        rst_i = 1'b1;
        req[1] = 1'b0;
        #1;
        chk("t5_async_ctrl", 256'({mem_en, mem_wr, ack0, ack1}), 256'(0));
        chk("t5_async_addr", 256'(mem_addr), 256'(0));
        step();
        rst_i = 1'b0;
        chk("t5_no_strobe", 256'(wr_cycles - w0), 256'(0));
        chk("t5_line_kept", mem[128], pat(128));
        c0 = cyc;
        issue(0, 1'b0, 32'h40, '0);
        wait_acks(1'b1, 1'b0, 40);
        chk("t5_after_ack_cycle", 256'(ack_cyc[0]), 256'(c0 + 5));
        chk("t5_after_rdata", ack_rdata[0], pat(16));

        // 6: random traffic
        for (int p = 0; p < 2; p++) begin
            issued[p] = 0; acked0[p] = ack_cnt[p]; age[p] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            mem_ack = ($urandom_range(3) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && !ack_seen[p] && $urandom_range(9) < 3) begin
                    issue(p, 1'($urandom_range(1)), {22'd0, 8'($urandom_range(255)), 2'b00}, rand_line());
                    issued[p]++;
                    age[p] = 0;
                end
            end
            step();
            for (int p = 0; p < 2; p++) begin
                if (req[p]) age[p]++;
                if (age[p] > 300) begin
                    chk("t6_starved", 256'(age[p]), 256'(0));
                    req[p] = 1'b0;
                    age[p] = 0;
                end
            end
        end
        mem_ack = 1'b1;
        for (int n = 0; n < 100 && (req[0] || req[1]); n++) step();
        step(); step();
        chk("t6_acks_port0", 256'(ack_cnt[0] - acked0[0]), 256'(issued[0]));
        chk("t6_acks_port1", 256'(ack_cnt[1] - acked0[1]), 256'(issued[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
